// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: shared state encoding, slot geometry and register indices
package proc_seq_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WB} state_t;
    localparam int DATA_W_DEF  = 24;
    localparam int SLOT_W      = 3;
    localparam int NSLOT       = DATA_W_DEF / SLOT_W;
    localparam int CNT_REG_DEF = 8;
    localparam int PROC1       = 6;
    localparam int PROC2       = 7;
    localparam logic [SLOT_W-1:0] OP_END = 3'b000;
endpackage

// File: rtl/proc_seq_if.sv
// proc_seq_if: regfile read/write port and step handshake toward the move engine
interface proc_seq_if #(parameter int DATA_W = 24, parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] rf_src;
    logic [DATA_W-1:0] rf_rdata;
    logic rf_we;
    logic [ADDR_W-1:0] rf_dst;
    logic [DATA_W-1:0] rf_wdata;
    logic step_valid;
    logic [proc_seq_pkg::SLOT_W-1:0] step_op;
    logic step_ready;
    modport master (output rf_src, rf_we, rf_dst, rf_wdata, step_valid, step_op,
                    input rf_rdata, step_ready);
    modport slave (input rf_src, rf_we, rf_dst, rf_wdata, step_valid, step_op,
                   output rf_rdata, step_ready);
endinterface

// File: rtl/proc_sequencer.sv
// proc_sequencer: fetches a procedure word, issues its 3-bit steps LSB first,
// then writes the executed-step count back to the regfile
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 4,
    parameter int CNT_REG = CNT_REG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    proc_seq_if.master        bus
);
    localparam int CW = $clog2(NSLOT + 1);
    localparam logic [CW-1:0] LAST = CW'(NSLOT - 1);

    state_t state, state_nx;
    logic [DATA_W-1:0] shift;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic hs;

    assign hs             = bus.step_valid & bus.step_ready;
    assign busy           = state != IDLE;
    assign done           = state == WB;
    assign bus.rf_src     = addr;
    assign bus.rf_we      = state == WB;
    assign bus.rf_dst     = (state == WB) ? ADDR_W'(CNT_REG) : '0;
    assign bus.rf_wdata   = (state == WB) ? DATA_W'(cnt) : '0;
    assign bus.step_valid = state == ISSUE;
    assign bus.step_op    = (state == ISSUE) ? shift[SLOT_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // The slot after the current one decides whether this handshake ends the procedure
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = start ? FETCH : IDLE;
            FETCH: state_nx = abort ? IDLE : (bus.rf_rdata[SLOT_W-1:0] == OP_END) ? WB : ISSUE;
            ISSUE: state_nx = abort ? IDLE :
                              (hs && (shift[2*SLOT_W-1:SLOT_W] == OP_END || cnt == LAST)) ? WB : ISSUE;
            WB:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift <= '0;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr <= proc_addr;
                cnt  <= '0;
            end
            if (state == FETCH) shift <= bus.rf_rdata;
            if (hs) begin
                shift <= shift >> SLOT_W;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed procedures with a scoreboard monitor on steps and writebacks
module tb_proc_sequencer;
    import proc_seq_pkg::*;

    typedef struct {bit wb; int val; int at;} exp_t;

    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [3:0] proc_addr = '0;
    logic busy, done;
    logic [23:0] rf [16];
    exp_t q[$];
    int cyc = 0, n_cmp = 0, n_bad = 0, base;
    int seq7[$] = '{1, 2, 3, 4, 5, 6, 7};
    int seq8[$] = '{7, 7, 7, 7, 7, 7, 7, 7};
    int seq3[$] = '{1, 2, 3};
    int seq2[$] = '{1, 2};
    int none[$];

    proc_seq_if bus();

    proc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .proc_addr(proc_addr),
        .abort(abort), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.rf_rdata = rf[bus.rf_src];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.step_valid && bus.step_ready) begin
                if (q.size() == 0) fail("extra_step");
                else begin
                    e = q.pop_front();
                    chk("step_kind", 32'(e.wb), 0);
                    chk("step_op", 32'(bus.step_op), e.val);
                    chk("step_cycle", cyc, e.at);
                end
            end
            if (bus.rf_we) begin
                if (q.size() == 0) fail("extra_write");
                else begin
                    e = q.pop_front();
                    chk("wb_kind", 32'(e.wb), 1);
                    chk("wb_data", 32'(bus.rf_wdata), e.val);
                    chk("wb_dst", 32'(bus.rf_dst), CNT_REG_DEF);
                    chk("wb_done", 32'(done), 1);
                    chk("wb_cycle", cyc, e.at);
                end
            end
            if (done && !bus.rf_we) fail("done_without_write");
        end
    end

    task automatic push_seq(input int ops[$], input int b, input int sk, input int sl);
        foreach (ops[k]) q.push_back('{1'b0, ops[k], b + 1 + k + (k >= sk ? sl : 0)});
        q.push_back('{1'b1, ops.size(), b + 1 + ops.size() + (ops.size() > sk ? sl : 0)});
    endtask

    task automatic do_start(input int a, output int b);
        @(negedge clk);
        start = 1;
        proc_addr = 4'(a);
        @(posedge clk);
        #1 start = 0;
        b = cyc;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            step_cycle();
            k++;
        end
        if (q.size() != 0) begin
            fail({name, "_timeout"});
            q.delete();
        end
        chk({name, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (rf[i]) rf[i] = '0;
        rf[PROC2] = 24'h1F58D1;
        rf[PROC1] = 24'h000000;
        rf[3]     = 24'hFFFFFF;
        bus.step_ready = 1;
        repeat (3) step_cycle();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(bus.step_valid), 0);
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_src", 32'(bus.rf_src), 0);
        chk("rst_wdata", 32'(bus.rf_wdata), 0);
        rst_n = 1;
        repeat (2) step_cycle();
        chk("idle_busy", 32'(busy), 0);

        do_start(PROC2, base);
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_src", 32'(bus.rf_src), PROC2);
        push_seq(seq7, base, 99, 0);
        drain("t1");

        do_start(PROC1, base);
        push_seq(none, base, 99, 0);
        drain("t2");

        do_start(3, base);
        push_seq(seq8, base, 99, 0);
        drain("t3");

        do_start(PROC2, base);
        push_seq(seq7, base, 1, 3);
        step_cycle();
        step_cycle();
        bus.step_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.step_valid), 1);
            chk("stall_op", 32'(bus.step_op), 2);
            @(posedge clk);
            #1;
        end
        bus.step_ready = 1;
        drain("t4");

        do_start(PROC2, base);
        push_seq(seq3, base, 99, 0);
        void'(q.pop_back());
        step_cycle();
        step_cycle();
        start = 1;
        proc_addr = 4'(PROC1);
        step_cycle();
        start = 0;
        abort = 1;
        step_cycle();
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_we", 32'(bus.rf_we), 0);
        chk("abort_done", 32'(done), 0);
        repeat (3) step_cycle();
        chk("abort_q_empty", q.size(), 0);
        do_start(PROC1, base);
        push_seq(none, base, 99, 0);
        drain("t5_fresh");

        do_start(PROC2, base);
        push_seq(seq2, base, 99, 0);
        void'(q.pop_back());
        step_cycle();
        step_cycle();
        step_cycle();
        rst_n = 0;
        step_cycle();
        chk("rst_mid_valid", 32'(bus.step_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_we", 32'(bus.rf_we), 0);
        chk("rst_mid_q_empty", q.size(), 0);
        rst_n = 1;
        step_cycle();
        do_start(PROC2, base);
        push_seq(seq7, base, 99, 0);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
